// File: rtl/estu_stack_pkg.sv
// Shared definitions for the spike index packer: default geometry and the
// packer state encoding.
package estu_stack_pkg;

    // Default spike bits per input word (power of two, at least 2).
    localparam int unsigned SPK_W_DEF       = 16;
    // Default index / count width, equal to the downstream stack data width.
    localparam int unsigned IDX_W_DEF       = 10;
    // Default maximum number of indices pushed per frame.
    localparam int unsigned MAX_ENTRIES_DEF = 128;

    // Packer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_COUNT = 2'd3
    } pkr_state_e;

endpackage : estu_stack_pkg

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: returns the position of the least
// significant set bit of vec_i and flags an all-zero input.
module lsb_prio_enc #(
    parameter int SPK_W = 16
) (
    input  logic [SPK_W-1:0]         vec_i,
    output logic [$clog2(SPK_W)-1:0] idx_o,
    output logic                     zero_o
);

    localparam int BIT_W = $clog2(SPK_W);

    // Walk from the top bit down so the lowest set bit is the last to win.
    always_comb begin
        idx_o = {BIT_W{1'b0}};
        for (int i = SPK_W - 1; i >= 0; i--) begin
            idx_o = vec_i[i] ? i[BIT_W-1:0] : idx_o;
        end
    end

    assign zero_o = ~|vec_i;

endmodule : lsb_prio_enc

// File: rtl/spike_index_packer.sv
// Spike index packer: accepts frames of SPK_W-bit spike words and pushes the
// index of every active neuron, one per cycle, followed by a per-frame count.
// Indices beyond MAX_ENTRIES are dropped and flagged with a sticky overflow.
module spike_index_packer
    import estu_stack_pkg::*;
#(
    parameter int SPK_W       = SPK_W_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int MAX_ENTRIES = MAX_ENTRIES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             spk_valid,
    output logic             spk_ready,
    input  logic [SPK_W-1:0] spk_data,
    input  logic             spk_last,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx_data,
    output logic             cnt_valid,
    output logic [IDX_W-1:0] cnt_data,
    output logic             busy,
    output logic             overflow
);

    localparam int BIT_W  = $clog2(SPK_W);
    localparam int WCNT_W = IDX_W - BIT_W;

    localparam logic [SPK_W-1:0]  SPK_ONE  = {{(SPK_W-1){1'b0}}, 1'b1};
    localparam logic [SPK_W-1:0]  SPK_ZERO = {SPK_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  MAX_CNT  = IDX_W'(MAX_ENTRIES);

    pkr_state_e        state_q, state_d;
    logic [SPK_W-1:0]  mask_q, mask_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]  act_cnt_q, act_cnt_d;
    logic              last_q, last_d;
    logic              overflow_q, overflow_d;

    logic [BIT_W-1:0]  lsb_idx_s;
    logic              mask_zero_s;
    logic [SPK_W-1:0]  mask_clr_s;
    logic              last_bit_s;
    logic              full_s;
    logic              word_zero_s;

    lsb_prio_enc #(
        .SPK_W (SPK_W)
    ) u_lsb_prio_enc (
        .vec_i  (mask_q),
        .idx_o  (lsb_idx_s),
        .zero_o (mask_zero_s)
    );

    // Mask with its lowest set bit removed; empty means this is the word's last index.
    assign mask_clr_s  = mask_q & (mask_q - SPK_ONE);
    assign last_bit_s  = (mask_clr_s == SPK_ZERO);
    assign full_s      = (act_cnt_q >= MAX_CNT);
    assign word_zero_s = (spk_data == SPK_ZERO);

    // State register; reset returns to IDLE, aborting any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (spk_valid) begin
                    if (!word_zero_s) begin
                        state_d = ST_SCAN;
                    end else if (spk_last) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SCAN: begin
                if (last_bit_s) begin
                    state_d = last_q ? ST_COUNT : ST_LOAD;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_COUNT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: mask, word/entry counters, frame-last flag, overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= SPK_ZERO;
            word_cnt_q <= {WCNT_W{1'b0}};
            act_cnt_q  <= {IDX_W{1'b0}};
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            word_cnt_q <= word_cnt_d;
            act_cnt_q  <= act_cnt_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath next values per state.
    always_comb begin
        mask_d     = mask_q;
        word_cnt_d = word_cnt_q;
        act_cnt_d  = act_cnt_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d     = SPK_ZERO;
                    word_cnt_d = {WCNT_W{1'b0}};
                    act_cnt_d  = {IDX_W{1'b0}};
                    last_d     = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    mask_d     = mask_q;
                end
            end
            ST_LOAD: begin
                if (spk_valid) begin
                    mask_d = spk_data;
                    last_d = spk_last;
                    if (word_zero_s) begin
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                end else begin
                    mask_d = mask_q;
                end
            end
            ST_SCAN: begin
                mask_d = mask_clr_s;
                // Once the frame budget is used up, keep draining bits but drop them.
                if (full_s) begin
                    overflow_d = 1'b1;
                end else begin
                    act_cnt_d  = act_cnt_q + IDX_ONE;
                end
                if (last_bit_s) begin
                    word_cnt_d = word_cnt_q + WCNT_ONE;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            ST_COUNT: begin
                mask_d = mask_q;
            end
            default: begin
                mask_d = mask_q;
            end
        endcase
    end

    // Outputs decoded from registered state only; spk_* never reaches idx_*.
    always_comb begin
        spk_ready = 1'b0;
        idx_valid = 1'b0;
        cnt_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                spk_ready = 1'b1;
            end
            ST_SCAN: begin
                idx_valid = !full_s && !mask_zero_s;
            end
            ST_COUNT: begin
                cnt_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        idx_data = {word_cnt_q, lsb_idx_s};
        cnt_data = act_cnt_q;
        overflow = overflow_q;
    end

endmodule : spike_index_packer

// File: tb/tb_spike_index_packer.sv
// Scoreboard bench for spike_index_packer (SPK_W=16, IDX_W=10, MAX_ENTRIES=4).
module tb_spike_index_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        spk_valid;
    logic        spk_ready;
    logic [15:0] spk_data;
    logic        spk_last;
    logic        idx_valid;
    logic [9:0]  idx_data;
    logic        cnt_valid;
    logic [9:0]  cnt_data;
    logic        busy;
    logic        overflow;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [9:0] exp_idx_q[$];
    logic [9:0] exp_cnt_q[$];

    spike_index_packer #(
        .SPK_W       (16),
        .IDX_W       (10),
        .MAX_ENTRIES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_data  (spk_data),
        .spk_last  (spk_last),
        .idx_valid (idx_valid),
        .idx_data  (idx_data),
        .cnt_valid (cnt_valid),
        .cnt_data  (cnt_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {spk_ready, idx_valid, cnt_valid, busy, overflow, idx_data, cnt_data}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one word and return 1 time unit after the accepting edge.
    task automatic send_word(input logic [15:0] data, input logic last);
        int n;
        @(negedge clk);
        spk_valid = 1'b1;
        spk_data  = data;
        spk_last  = last;
        n = 0;
        while (!spk_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            fail("send_word ready timeout");
        end
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        spk_data  = 16'h0000;
        spk_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail({name, " idle timeout"});
        end
        // Give the monitor a cycle after COUNT before checking the queues.
        @(negedge clk);
        check({name, " idx queue drained"}, exp_idx_q.size(), 32'd0);
        check({name, " cnt queue drained"}, exp_cnt_q.size(), 32'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents an index or a count.
    initial begin
        forever begin
            @(negedge clk);
            if (idx_valid) begin
                check("idx/cnt exclusive", {31'd0, cnt_valid}, 32'd0);
                check("spk_ready low in SCAN", {31'd0, spk_ready}, 32'd0);
                if (exp_idx_q.size() == 0) begin
                    $display("FAIL unexpected idx_valid: got idx %0d, expected none", idx_data);
                    n_total++;
                end else begin
                    check("idx_data", {22'd0, idx_data}, {22'd0, exp_idx_q.pop_front()});
                end
            end
            if (cnt_valid) begin
                if (exp_cnt_q.size() == 0) begin
                    $display("FAIL unexpected cnt_valid: got cnt %0d, expected none", cnt_data);
                    n_total++;
                end else begin
                    check("cnt_data", {22'd0, cnt_data}, {22'd0, exp_cnt_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        spk_valid = 1'b0;
        spk_data  = 16'h0000;
        spk_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset outputs");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle after reset");

        // Single word, two spikes at the extremes.
        exp_idx_q.push_back(10'd0);
        exp_idx_q.push_back(10'd15);
        exp_cnt_q.push_back(10'd2);
        pulse_start();
        check("busy in LOAD", {31'd0, busy}, 32'd1);
        send_word(16'h8001, 1'b1);
        wait_idle("0x8001");

        // Zero word advances the word counter; indices carry word number.
        exp_idx_q.push_back(10'd16);
        exp_idx_q.push_back(10'd17);
        exp_idx_q.push_back(10'd47);
        exp_cnt_q.push_back(10'd3);
        pulse_start();
        send_word(16'h0000, 1'b0);
        send_word(16'h0003, 1'b0);
        send_word(16'h8000, 1'b1);
        wait_idle("three words");

        // Overflow: eight spikes against a budget of four.
        exp_idx_q.push_back(10'd0);
        exp_idx_q.push_back(10'd1);
        exp_idx_q.push_back(10'd2);
        exp_idx_q.push_back(10'd3);
        exp_cnt_q.push_back(10'd4);
        pulse_start();
        send_word(16'h00FF, 1'b1);
        wait_idle("overflow frame");
        check("overflow sticky in IDLE", {31'd0, overflow}, 32'd1);
        repeat (3) @(negedge clk);
        check("overflow still set", {31'd0, overflow}, 32'd1);

        // Empty frame; start also clears overflow.
        exp_cnt_q.push_back(10'd0);
        pulse_start();
        check("overflow cleared by start", {31'd0, overflow}, 32'd0);
        send_word(16'h0000, 1'b0);
        send_word(16'h0000, 1'b1);
        wait_idle("empty frame");
        check("overflow empty frame", {31'd0, overflow}, 32'd0);

        // Reset on the second SCAN cycle aborts the frame without a count.
        exp_idx_q.push_back(10'd0);
        exp_idx_q.push_back(10'd1);
        pulse_start();
        send_word(16'h000F, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("outputs after mid-scan reset");
        repeat (4) @(negedge clk);
        check("aborted idx queue drained", exp_idx_q.size(), 32'd0);
        exp_idx_q.push_back(10'd4);
        exp_cnt_q.push_back(10'd1);
        pulse_start();
        send_word(16'h0010, 1'b1);
        wait_idle("frame after reset");

        // start pulsed mid-SCAN must not disturb the frame.
        exp_idx_q.push_back(10'd0);
        exp_idx_q.push_back(10'd4);
        exp_idx_q.push_back(10'd8);
        exp_cnt_q.push_back(10'd3);
        pulse_start();
        send_word(16'h0111, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("start mid-scan");
        check("idle after ignored start", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_spike_index_packer
